// File: rtl/serial_pattern_pkg.sv
// Shared types and the thermometer-code decode used by the serial pattern decoder
// and its reference model.
package serial_pattern_pkg;

    localparam int WIDTH = 8;
    localparam int AW    = 3;

    typedef enum logic {
        HUNT,
        RECEIVE
    } state_t;

    typedef struct packed {
        logic          legal;
        logic [AW-1:0] index;
    } thermo_t;

    // Legal words are a contiguous run of ones starting at bit 0; index is the top set bit.
    function automatic thermo_t thermo_decode(input logic [WIDTH-1:0] word);
        thermo_t result;
        result.legal = (word != '0) && ((word & (word + WIDTH'(1))) == '0);
        result.index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (word[i]) begin
                result.index = AW'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_pattern_decoder_if.sv
// Serial input and decoded-frame outputs of the serial pattern decoder.
interface serial_pattern_decoder_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 8
);

    logic             bit_in;
    logic             bit_valid;
    logic             sync;
    logic [WIDTH-1:0] word_out;
    logic [AW-1:0]    addr_out;
    logic             word_valid;
    logic             code_error;
    logic             sync_error;
    logic             locked;
    logic [CNT_W-1:0] repeat_cnt;

    modport master (
        output bit_in, bit_valid, sync,
        input  word_out, addr_out, word_valid, code_error, sync_error, locked, repeat_cnt
    );

    modport slave (
        input  bit_in, bit_valid, sync,
        output word_out, addr_out, word_valid, code_error, sync_error, locked, repeat_cnt
    );

endinterface

// File: rtl/serial_pattern_decoder_thermo_checker.sv
// Combinational thermometer-code check: a word is legal when its ones form one
// contiguous run from bit 0, and the address is the number of ones minus one.
module thermo_checker #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic [WIDTH-1:0] word,
    output logic             legal,
    output logic [AW-1:0]    addr
);

    logic [AW:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + {{AW{1'b0}}, word[i]};
        end
        legal = (word != '0) && ((word & (word + WIDTH'(1))) == '0);
        addr  = AW'(ones - (AW + 1)'(1));
    end

endmodule

// File: rtl/serial_pattern_decoder.sv
// Receive end of the serial thermometer link: frames bits into words, decodes
// the address and counts consecutive identical legal frames.
module serial_pattern_decoder #(
    parameter int WIDTH  = 8,
    parameter int AW     = 3,
    parameter int INVERT = 1,
    parameter int CNT_W  = 8
) (
    input logic                     clock,
    input logic                     clear,
    serial_pattern_decoder_if.slave bus
);

    import serial_pattern_pkg::*;

    state_t           state;
    logic [AW-1:0]    index;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] raw_word;
    logic [WIDTH-1:0] word;
    logic             legal;
    logic [AW-1:0]    addr;
    logic             have_prev;

    // The last bit is still on the line when the frame completes, so it is spliced in here.
    assign raw_word = {bus.bit_in, shreg[WIDTH-2:0]};
    assign word     = (INVERT != 0) ? ~raw_word : raw_word;

    thermo_checker #(
        .WIDTH(WIDTH),
        .AW   (AW)
    ) checker_i (
        .word (word),
        .legal(legal),
        .addr (addr)
    );

    always_ff @(posedge clock) begin
        if (!clear) begin
            state          <= HUNT;
            index          <= '0;
            shreg          <= '0;
            have_prev      <= 1'b0;
            bus.word_out   <= '0;
            bus.addr_out   <= '0;
            bus.word_valid <= 1'b0;
            bus.code_error <= 1'b0;
            bus.sync_error <= 1'b0;
            bus.locked     <= 1'b0;
            bus.repeat_cnt <= '0;
        end else begin
            bus.word_valid <= 1'b0;
            bus.sync_error <= 1'b0;
            if (bus.bit_valid) begin
                case (state)
                    HUNT: begin
                        if (bus.sync) begin
                            shreg      <= {{(WIDTH-1){1'b0}}, bus.bit_in};
                            index      <= AW'(1);
                            state      <= RECEIVE;
                            bus.locked <= 1'b1;
                        end
                    end
                    RECEIVE: begin
                        if (bus.sync && index != '0) begin
                            shreg          <= {{(WIDTH-1){1'b0}}, bus.bit_in};
                            index          <= AW'(1);
                            bus.sync_error <= 1'b1;
                            bus.repeat_cnt <= '0;
                            have_prev      <= 1'b0;
                        end else if (index == AW'(WIDTH - 1)) begin
                            index          <= '0;
                            bus.word_valid <= 1'b1;
                            bus.word_out   <= word;
                            bus.code_error <= ~legal;
                            if (legal) begin
                                // addr_out still holds the address of the previous legal frame.
                                bus.addr_out <= addr;
                                have_prev    <= 1'b1;
                                if (have_prev && addr == bus.addr_out) begin
                                    if (bus.repeat_cnt != '1) begin
                                        bus.repeat_cnt <= bus.repeat_cnt + CNT_W'(1);
                                    end
                                end else begin
                                    bus.repeat_cnt <= CNT_W'(1);
                                end
                            end else begin
                                bus.repeat_cnt <= '0;
                            end
                        end else begin
                            shreg[index] <= bus.bit_in;
                            index        <= index + AW'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_pattern_decoder.sv
// Directed bench for serial_pattern_decoder: stimulus queues expected frames,
// a negedge monitor pops and compares them when the decoder reports.
module tb_serial_pattern_decoder;

    import serial_pattern_pkg::*;

    localparam int CNT_W = 8;

    typedef struct {
        logic [7:0] word;
        logic [2:0] addr;
        logic       code_error;
        logic [7:0] repeat_cnt;
        int         due;
    } exp_t;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;

    exp_t exp_q[$];
    int   sync_q[$];
    exp_t e;
    int   sync_due;

    serial_pattern_decoder_if #(.WIDTH(WIDTH), .AW(AW), .CNT_W(CNT_W)) bus ();

    serial_pattern_decoder #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .INVERT(1),
        .CNT_W (CNT_W)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic send_bit(input logic b, input logic s);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        bus.sync      = s;
        @(posedge clock);
        #1;
        bus.bit_valid = 1'b0;
        bus.sync      = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] w, input logic [2:0] a, input logic ce, input logic [7:0] rc);
        exp_q.push_back('{word: w, addr: a, code_error: ce, repeat_cnt: rc, due: cycle});
    endtask

    task automatic send_frame(input logic [7:0] line, input logic s, input logic [7:0] w,
                              input logic [2:0] a, input logic ce, input logic [7:0] rc);
        for (int i = 0; i < 8; i++) begin
            send_bit(line[i], s && i == 0);
        end
        push_exp(w, a, ce, rc);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_word_out"}, bus.word_out, 0);
        check({tag, "_addr_out"}, bus.addr_out, 0);
        check({tag, "_word_valid"}, bus.word_valid, 0);
        check({tag, "_code_error"}, bus.code_error, 0);
        check({tag, "_sync_error"}, bus.sync_error, 0);
        check({tag, "_locked"}, bus.locked, 0);
        check({tag, "_repeat_cnt"}, bus.repeat_cnt, 0);
    endtask

    // Monitor: every word_valid / sync_error pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (bus.word_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_word_valid: got word 0x%0h at cycle %0d required no pulse",
                         bus.word_out, cycle);
            end else begin
                e = exp_q.pop_front();
                check("word_valid_cycle", cycle, e.due);
                check("word_out", bus.word_out, e.word);
                check("addr_out", bus.addr_out, e.addr);
                check("code_error", bus.code_error, e.code_error);
                check("repeat_cnt", bus.repeat_cnt, e.repeat_cnt);
            end
        end
        if (bus.sync_error === 1'b1) begin
            if (sync_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_sync_error: got pulse at cycle %0d required none", cycle);
            end else begin
                sync_due = sync_q.pop_front();
                check("sync_error_cycle", cycle, sync_due);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.sync      = 1'b0;

        // Reset held for two clocks while random bits arrive.
        for (int i = 0; i < 2; i++) begin
            bus.bit_in    = 1'($urandom_range(1));
            bus.bit_valid = 1'b1;
            bus.sync      = 1'b1;
            @(posedge clock);
        end
        #1;
        bus.bit_valid = 1'b0;
        bus.sync      = 1'b0;
        check_reset_state("reset");
        clear = 1'b1;

        // First bit of line frame F8 with sync locks the receiver.
        send_bit(1'b0, 1'b1);
        check("locked_after_sync", bus.locked, 1);
        begin
            logic [7:0] line;
            line = 8'hF8;
            for (int i = 1; i < 8; i++) send_bit(line[i], 1'b0);
        end
        push_exp(8'h07, 3'd2, 1'b0, 8'd1);

        for (int n = 0; n < 3; n++) send_frame(8'hF8, 1'b0, 8'h07, 3'd2, 1'b0, 8'(n + 2));
        send_frame(8'hFE, 1'b0, 8'h01, 3'd0, 1'b0, 8'd1);
        send_frame(8'hF0, 1'b0, 8'h0F, 3'd3, 1'b0, 8'd1);
        send_frame(8'hFA, 1'b0, 8'h05, 3'd3, 1'b1, 8'd0);
        send_frame(8'hFF, 1'b0, 8'h00, 3'd3, 1'b1, 8'd0);
        send_frame(8'hF0, 1'b0, 8'h0F, 3'd3, 1'b0, 8'd1);
        send_frame(8'hC0, 1'b1, 8'h3F, 3'd5, 1'b0, 8'd1);

        // Sync arriving at bit 4 drops the partial frame and restarts from that bit.
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        begin
            logic [7:0] line;
            line = 8'hE0;
            send_bit(line[0], 1'b1);
            sync_q.push_back(cycle);
            for (int i = 1; i < 8; i++) send_bit(line[i], 1'b0);
        end
        push_exp(8'h1F, 3'd4, 1'b0, 8'd1);
        send_frame(8'hE0, 1'b0, 8'h1F, 3'd4, 1'b0, 8'd2);

        // Five-cycle gap mid-frame, with sync raised but not qualified by bit_valid.
        begin
            logic [7:0] line;
            line = 8'h80;
            for (int i = 0; i < 4; i++) send_bit(line[i], 1'b0);
            bus.sync = 1'b1;
            repeat (5) @(posedge clock);
            #1;
            bus.sync = 1'b0;
            for (int i = 4; i < 8; i++) send_bit(line[i], 1'b0);
        end
        push_exp(8'h7F, 3'd6, 1'b0, 8'd1);

        // Repeat counter runs up to 255 and holds there.
        for (int n = 0; n < 256; n++) begin
            send_frame(8'h80, 1'b0, 8'h7F, 3'd6, 1'b0, (n + 2 > 255) ? 8'd255 : 8'(n + 2));
        end

        // Reset in the middle of a frame discards it and returns to HUNT.
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        clear         = 1'b0;
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        @(posedge clock);
        #1;
        clear         = 1'b1;
        bus.bit_valid = 1'b0;
        check_reset_state("midframe_reset");

        // Unsynced bits in HUNT are ignored; the next synced frame decodes normally.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        check("hunt_ignores_bits", bus.locked, 0);
        send_frame(8'h00, 1'b1, 8'hFF, 3'd7, 1'b0, 8'd1);
        send_frame(8'h00, 1'b0, 8'hFF, 3'd7, 1'b0, 8'd2);

        for (int i = 0; i < 20 && (exp_q.size() != 0 || sync_q.size() != 0); i++) begin
            @(posedge clock);
        end
        repeat (2) @(posedge clock);
        check("pending_frames", exp_q.size(), 0);
        check("pending_sync_errors", sync_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
